// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg -- shared UART definitions for the receiver and transmitter.
//   * uart_state_e : line-state encoding (IDLE=0, START_BIT=1, DATA_BIT=2,
//                    STOP_BIT=3)
//   * FCLK_DEFAULT / FUART_DEFAULT : default clock and baud rate
//   * CNT_W        : width of the per-bit cycle counter
//   * calc_divider : clocks per bit for a given clock / baud pair
// ---------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START_BIT = 2'd1,
      DATA_BIT  = 2'd2,
      STOP_BIT  = 2'd3
   } uart_state_e;

   localparam int unsigned FCLK_DEFAULT  = 32'd50000000;
   localparam int unsigned FUART_DEFAULT = 32'd9600;
   localparam int unsigned CNT_W         = 32'd25;

   // Integer clocks per bit; any remainder is dropped.
   function automatic int unsigned calc_divider(input int unsigned fclk,
                                                input int unsigned fuart);
      return fclk / fuart;
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// ---------------------------------------------------------------------------
// uart_rx_if -- serial line and byte-handshake bundle of the UART receiver.
//   Rx_in      : serial line into the receiver (idle high)
//   data_ack   : consumer acknowledge of data_out
//   data_out   : last correctly received byte
//   data_valid : data_out holds an unacknowledged byte
//   frame_err  : one-clock pulse on a low stop bit
//   overrun    : sticky, a good frame arrived while data_valid was high
//   busy       : receiver is inside a frame
// master = receiver side, slave = line driver / byte consumer side.
// ---------------------------------------------------------------------------
interface uart_rx_if;

   logic       Rx_in;
   logic       data_ack;
   logic [7:0] data_out;
   logic       data_valid;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   modport master (
      input  Rx_in, data_ack,
      output data_out, data_valid, frame_err, overrun, busy
   );

   modport slave (
      output Rx_in, data_ack,
      input  data_out, data_valid, frame_err, overrun, busy
   );

endinterface

// File: rtl/rx_sync.sv
// ---------------------------------------------------------------------------
// rx_sync -- two-flop synchronizer for the asynchronous serial line.
//   clk_i : receiver clock
//   rst_i : asynchronous active-high reset, both flops reset to 1 (line idle)
//   d_i   : asynchronous input
//   q_o   : synchronized output
// ---------------------------------------------------------------------------
module rx_sync (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // Two-stage capture; resetting to 1 keeps the line looking idle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- 8N1 UART receiver, LSB first, mid-bit sampling.
//   Fclk, Fuart : clock frequency and baud rate (Hz, bit/s)
//   clk_Rx      : single clock, rising edge
//   reset       : asynchronous active-high reset
//   bus         : uart_rx_if.master (line input, byte handshake, status)
// A good stop bit loads data_out / data_valid on the same edge that takes
// the stop sample, so they are visible one clock after the sampling cycle.
// ---------------------------------------------------------------------------
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned Fclk  = FCLK_DEFAULT,
   parameter int unsigned Fuart = FUART_DEFAULT
) (
   input  logic      clk_Rx,
   input  logic      reset,
   uart_rx_if.master bus
);

   localparam int unsigned      divider  = calc_divider(Fclk, Fuart);
   localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(divider - 32'd1);
   localparam logic [CNT_W-1:0] HALF_END = CNT_W'(divider / 32'd2 - 32'd1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

   logic             rx_s;
   logic             rx_prev_q;
   uart_state_e      state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       bit_idx_q;
   logic [7:0]       shift_q;
   logic [7:0]       data_out_q;
   logic             data_valid_q;
   logic             frame_err_q;
   logic             overrun_q;
   logic             busy_q;

   rx_sync u_rx_sync (
      .clk_i (clk_Rx),
      .rst_i (reset),
      .d_i   (bus.Rx_in),
      .q_o   (rx_s)
   );

   // Receive FSM with its counters, shift register and registered outputs.
   always_ff @(posedge clk_Rx or posedge reset) begin
      if (reset) begin
         rx_prev_q    <= 1'b1;
         state_q      <= IDLE;
         cnt_q        <= '0;
         bit_idx_q    <= 3'd0;
         shift_q      <= 8'h00;
         data_out_q   <= 8'h00;
         data_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         rx_prev_q   <= rx_s;
         frame_err_q <= 1'b0;

         // Ack is applied first; a good stop below may reload on top of it.
         if (bus.data_ack && data_valid_q) begin
            data_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
         end else begin
            data_valid_q <= data_valid_q;
         end

         case (state_q)
            IDLE: begin
               cnt_q     <= '0;
               bit_idx_q <= 3'd0;
               // Edge, not level: a line stuck low never retriggers.
               if (rx_prev_q && !rx_s) begin
                  state_q <= START_BIT;
                  busy_q  <= 1'b1;
               end else begin
                  busy_q  <= 1'b0;
               end
            end

            START_BIT: begin
               if (cnt_q == HALF_END) begin
                  cnt_q <= '0;
                  if (!rx_s) begin
                     state_q <= DATA_BIT;
                  end else begin
                     state_q <= IDLE;   // false start, nothing reported
                     busy_q  <= 1'b0;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end

            DATA_BIT: begin
               if (cnt_q == BIT_END) begin
                  cnt_q              <= '0;
                  shift_q[bit_idx_q] <= rx_s;
                  bit_idx_q          <= bit_idx_q + 3'd1;  // wraps to 0 after bit 7
                  if (bit_idx_q == 3'd7) begin
                     state_q <= STOP_BIT;
                  end else begin
                     state_q <= DATA_BIT;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end

            STOP_BIT: begin
               if (cnt_q == BIT_END) begin
                  cnt_q   <= '0;
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  if (rx_s) begin
                     if (!data_valid_q || bus.data_ack) begin
                        data_out_q   <= shift_q;
                        data_valid_q <= 1'b1;
                     end else begin
                        overrun_q    <= 1'b1;   // keep old byte, drop new one
                     end
                  end else begin
                     frame_err_q <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end

            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.data_out   = data_out_q;
   assign bus.data_valid = data_valid_q;
   assign bus.frame_err  = frame_err_q;
   assign bus.overrun    = overrun_q;
   assign bus.busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx with Fclk=16, Fuart=1
// (16 clocks per bit). A frame-level reference model tracks the expected
// byte, valid, overrun and frame-error count from the protocol rules.
// ---------------------------------------------------------------------------
module tb_uart_rx;

   localparam int DIV         = 16;
   localparam int FRAME_EDGES = 10 * DIV;
   // Edges from first start-bit drive to the stop sample: two synchronizer
   // edges, half a bit to the start check, then nine full bits.
   localparam int STOP_EDGE   = 2 + DIV / 2 + 9 * DIV;

   logic clk = 1'b0;
   logic rst = 1'b1;

   uart_rx_if bus ();

   uart_rx #(.Fclk(16), .Fuart(1)) dut (
      .clk_Rx (clk),
      .reset  (rst),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state.
   logic [7:0] m_data  = 8'h00;
   bit         m_valid = 1'b0;
   bit         m_ovr   = 1'b0;
   int         m_fe    = 0;

   // Pulse and busy monitors, sampled on the falling edge.
   int fe_seen     = 0;
   int busy_cycles = 0;
   always @(negedge clk) begin
      if (bus.frame_err === 1'b1) fe_seen++;
      if (bus.busy === 1'b1) busy_cycles++;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      check_eq({tag, "/data_out"},   32'(bus.data_out),   32'(m_data));
      check_eq({tag, "/data_valid"}, 32'(bus.data_valid), 32'(m_valid));
      check_eq({tag, "/overrun"},    32'(bus.overrun),    32'(m_ovr));
      check_eq({tag, "/busy"},       32'(bus.busy),       32'd0);
      check_eq({tag, "/fe_count"},   32'(fe_seen),        32'(m_fe));
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_ack(input string tag);
      @(negedge clk);
      bus.data_ack = 1'b1;
      if (m_valid) begin
         m_valid = 1'b0;
         m_ovr   = 1'b0;
      end
      @(negedge clk);
      bus.data_ack = 1'b0;
      #2;
      check_outputs(tag);
   endtask

   // One 8N1 frame; optional ack on the stop-sample edge, optional reset
   // asserted at edge abort_at (which abandons the frame).
   task automatic send_frame(input string tag, input logic [7:0] b, input bit stop_b,
                             input bit ack_stop, input int abort_at);
      bit pre_valid;
      bit dv_before;
      bit dv_after;
      pre_valid = m_valid;
      dv_before = 1'b0;
      dv_after  = 1'b0;
      for (int e = 0; e < FRAME_EDGES; e++) begin
         @(negedge clk);
         if (e == abort_at) begin
            rst = 1'b1;
            #1;
            check_eq({tag, "/rst_data_out"},   32'(bus.data_out),   32'h0);
            check_eq({tag, "/rst_data_valid"}, 32'(bus.data_valid), 32'h0);
            check_eq({tag, "/rst_frame_err"},  32'(bus.frame_err),  32'h0);
            check_eq({tag, "/rst_overrun"},    32'(bus.overrun),    32'h0);
            check_eq({tag, "/rst_busy"},       32'(bus.busy),       32'h0);
            m_data  = 8'h00;
            m_valid = 1'b0;
            m_ovr   = 1'b0;
            bus.Rx_in    = 1'b1;
            bus.data_ack = 1'b0;
            idle(3);
            rst = 1'b0;
            return;
         end
         if (e < DIV)          bus.Rx_in = 1'b0;
         else if (e < 9 * DIV) bus.Rx_in = b[e / DIV - 1];
         else                  bus.Rx_in = stop_b;
         bus.data_ack = ack_stop && (e == STOP_EDGE);
         if (e == STOP_EDGE)     dv_before = bus.data_valid;
         if (e == STOP_EDGE + 1) dv_after  = bus.data_valid;
      end
      @(negedge clk);
      bus.Rx_in    = 1'b1;
      bus.data_ack = 1'b0;
      // Frame-level model update.
      if (stop_b) begin
         if (!m_valid || ack_stop) begin
            m_data  = b;
            m_valid = 1'b1;
            m_ovr   = 1'b0;
         end else begin
            m_ovr   = 1'b1;
         end
      end else begin
         m_fe++;
      end
      #2;
      check_eq({tag, "/dv_before_stop"}, 32'(dv_before), 32'(pre_valid));
      check_eq({tag, "/dv_after_stop"},  32'(dv_after),  32'(m_valid));
      check_outputs(tag);
   endtask

   initial begin
      int busy_base;
      int fe_base;
      bus.Rx_in    = 1'b1;
      bus.data_ack = 1'b0;
      idle(3);
      #2;
      check_outputs("reset");
      rst = 1'b0;
      idle(4);

      // Basic good frame, then acknowledge it.
      send_frame("a5", 8'hA5, 1'b1, 1'b0, -1);
      do_ack("a5_ack");
      idle(4);

      // False start: low for 4 clocks only.
      busy_base = busy_cycles;
      fe_base   = fe_seen;
      @(negedge clk);
      bus.Rx_in = 1'b0;
      idle(4);
      bus.Rx_in = 1'b1;
      idle(30);
      #2;
      check_eq("false_start/busy_seen", 32'(busy_cycles > busy_base), 32'd1);
      check_eq("false_start/fe_delta",  32'(fe_seen - fe_base),       32'd0);
      check_outputs("false_start");

      // Framing error.
      send_frame("3c_bad_stop", 8'h3C, 1'b0, 1'b0, -1);
      idle(4);

      // Overrun, then one ack clears valid and overrun.
      send_frame("11", 8'h11, 1'b1, 1'b0, -1);
      idle(4);
      send_frame("22_overrun", 8'h22, 1'b1, 1'b0, -1);
      do_ack("overrun_ack");
      idle(4);

      // Reset in the middle of bit 4 of 0xFF with a byte pending.
      send_frame("33", 8'h33, 1'b1, 1'b0, -1);
      idle(4);
      send_frame("ff_abort", 8'hFF, 1'b1, 1'b0, 10 + 4 * DIV + DIV / 2);
      idle(4);
      send_frame("5a_after_rst", 8'h5A, 1'b1, 1'b0, -1);
      do_ack("5a_ack");
      idle(4);

      // Back-to-back with ack coincident with the second stop sample.
      send_frame("b2b_01", 8'h01, 1'b1, 1'b0, -1);
      send_frame("b2b_02_ack", 8'h02, 1'b1, 1'b1, -1);
      idle(4);

      // Randomized frames against the model.
      for (int i = 0; i < 12; i++) begin
         logic [7:0] rb;
         bit         rstop;
         bit         rack;
         rb    = 8'($urandom);
         rstop = ($urandom_range(0, 3) != 0);
         rack  = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 1) == 1) do_ack("rand_ack");
         send_frame("rand", rb, rstop, rack, -1);
         idle(4);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter Fclk, default 50000000, meaning clock frequency in Hz.
REQ-002 SHALL have parameter Fuart, default 9600, meaning baud rate in bit/s.
REQ-003 SHALL have derived parameter divider = Fclk / Fuart (integer), meaning clocks per bit; 5208 at defaults.
REQ-004 SHALL have port clk_Rx  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port Rx_in  input  1  asynchronous serial line, idle high, 8N1 framing, LSB first.
REQ-007 SHALL have port data_ack  input  1  consumer acknowledge of data_out.
REQ-008 SHALL have port data_out  output  8  last correctly received byte.
REQ-009 SHALL have port data_valid  output  1  data_out holds an unacknowledged byte.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse when a stop bit is sampled low.
REQ-011 SHALL have port overrun  output  1  sticky flag: a good frame arrived while data_valid was high.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL pass Rx_in through a 2-flop synchronizer; all decisions use the synchronized value (rx_s).
REQ-014 SHALL implement the states IDLE, START_BIT, DATA_BIT and STOP_BIT, with a 25-bit cycle counter cnt and a 3-bit bit index.
REQ-015 IDLE: on rx_s high-to-low transition, SHALL clear cnt and enter START_BIT; a line held low does not retrigger.
REQ-016 START_BIT: at cnt == divider/2 - 1, SHALL enter DATA_BIT with cnt cleared if rx_s is low; otherwise false start, SHALL return to IDLE with no output change.
REQ-017 DATA_BIT: at cnt == divider - 1, SHALL sample rx_s into shift-register position bit index (LSB first) and clear cnt; after the 8th sample, SHALL enter STOP_BIT.
REQ-018 STOP_BIT: at cnt == divider - 1, SHALL sample rx_s and return to IDLE.
REQ-019 Stop sample high with data_valid low (or data_ack high that cycle): SHALL load data_out and set data_valid on the next edge; latency is 1 clock after the stop sample.
REQ-020 Stop sample high with data_valid high and data_ack low: SHALL set overrun, keep data_out unchanged and discard the new byte.
REQ-021 Stop sample low: SHALL pulse frame_err for exactly 1 clock, discard the byte and leave data_valid and data_out unchanged.
REQ-022 data_ack high while data_valid is high: SHALL clear data_valid and overrun on the next edge; data_ack while data_valid is low SHALL be ignored.
REQ-023 Simultaneous data_ack and good stop sample: ack takes priority, then the new byte loads; data_valid stays high and overrun stays low.
REQ-024 cnt SHALL never exceed divider - 1; cnt and bit index SHALL wrap to 0 at each bit boundary.

Reset
REQ-025 reset high SHALL immediately force: state IDLE, cnt 0, bit index 0, shift register 0, data_out 8'h00, data_valid 0, frame_err 0, overrun 0, busy 0, synchronizer flops 1.
REQ-026 Reset asserted mid-frame SHALL abandon the frame with no output pulse; after release, reception restarts only on a fresh falling edge.

Structure
REQ-027 State encodings (IDLE=0, START_BIT=1, DATA_BIT=2, STOP_BIT=3) and the default Fclk/Fuart values SHALL live in the shared package uart_pkg, used by both Tx and Rx.
REQ-028 The synchronizer SHALL be the single sub-module rx_sync (2 flops, reset value 1); all other logic stays in uart_rx.

Verification (Fclk=16, Fuart=1, so divider=16)
REQ-029 Send 0xA5 with stop=1: data_out=0xA5 and data_valid=1 one clock after the stop sample; frame_err=0.
REQ-030 Rx_in low for 4 clocks, then high: busy rises, returns to IDLE at the half-bit check; data_valid and frame_err stay 0.
REQ-031 Send 0x3C with stop=0: single 1-clock frame_err pulse; data_valid stays 0; data_out unchanged.
REQ-032 Send 0x11 then 0x22 with no ack: overrun=1, data_out=0x11; one data_ack clears data_valid and overrun.
REQ-033 Assert reset at bit 4 of 0xFF, release, then send 0x5A: all outputs at reset values during reset; 0x5A received correctly.
REQ-034 Send back-to-back 0x01, 0x02 with data_ack coincident with the second stop sample: data_out=0x02, data_valid=1, overrun=0.
